// File: rtl/riscv_pkg.sv
// Shared RV32 load/store definitions: funct3 codes, LSU state encoding, request record, lane helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

   // Load/store width encodings carried in funct3
   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2,
      RESP   = 2'd3
   } lsu_state_t;

   // Latched request fields other than the address (whose width is a top-level parameter)
   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [31:0] wdata;
   } lsu_req_t;

   // Byte enables for an access of the given width starting at byte offset a
   function automatic logic [3:0] lsu_byte_en(input logic [2:0] funct3, input logic [1:0] a);
      logic [3:0] be;
      case (funct3[1:0])
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << a;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Reserved widths, and unsigned variants used with a store, are illegal
   function automatic logic lsu_illegal(input logic we, input logic [2:0] funct3);
      logic ill;
      case (funct3)
         LS_B, LS_H, LS_W: ill = 1'b0;
         LS_BU, LS_HU:     ill = we;
         default:          ill = 1'b1;
      endcase
      return ill;
   endfunction

   // Halfwords need an even address, words a multiple of four
   function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] a);
      logic mis;
      case (funct3[1:0])
         2'b01:   mis = a[0];
         2'b10:   mis = (a != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/halfword/word from a memory word and sign- or zero-extends it.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
module lsu_load_align
   import riscv_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  a,
   input  logic [2:0]  funct3,
   output logic [31:0] ext_data
);

   logic [31:0] shifted;

   // Move the addressed lane down to bit 0, then extend according to width and signedness
   always_comb begin
      shifted = rdata >> {a, 3'b000};
      case (funct3)
         LS_B:    ext_data = {{24{shifted[7]}}, shifted[7:0]};
         LS_BU:   ext_data = {24'h000000, shifted[7:0]};
         LS_H:    ext_data = {{16{shifted[15]}}, shifted[15:0]};
         LS_HU:   ext_data = {16'h0000, shifted[15:0]};
         default: ext_data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// CPU-to-data-memory bridge: one load/store per handshake with alignment checks, lane formatting and extension.
// Latency: store 2 cycles, load 3 cycles, error 1 cycle after accept, plus one per cycle mem_ready_i is low.
// Backpressure: req_ready_o only in IDLE; the ISSUE strobe and its address/data are held until mem_ready_i.
module load_store_unit
   import riscv_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  resp_valid_o,
   output logic [31:0]           resp_rdata_o,
   output logic                  resp_err_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_wdata_o,
   output logic [3:0]            mem_byte_en_o,
   input  logic [31:0]           mem_rdata_i,
   input  logic                  mem_ready_i
);

   generate
      if (DATA_WIDTH != 32) begin : g_bad_data_width
         $error("load_store_unit only supports DATA_WIDTH = 32");
      end
   endgenerate

   lsu_state_t            state_q, state_d;
   lsu_req_t              req_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  err_q;
   logic [31:0]           rdata_q;
   logic                  req_err;
   logic [31:0]           wdata_fmt;
   logic [31:0]           load_data;

   assign req_err = lsu_illegal(req_we_i, req_funct3_i)
                  | lsu_misaligned(req_funct3_i, req_addr_i[1:0]);

   lsu_load_align u_load_align (
      .rdata    (mem_rdata_i),
      .a        (addr_q[1:0]),
      .funct3   (req_q.funct3),
      .ext_data (load_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode: errors skip the memory entirely, loads take an extra cycle for read data
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_valid_i) state_d = req_err ? RESP : ISSUE;
         ISSUE:   if (mem_ready_i) state_d = req_q.we ? RESP : RDWAIT;
         RDWAIT:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch, error flag and registered load result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_q   <= '0;
         addr_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid_i) begin
                  req_q.we     <= req_we_i;
                  req_q.funct3 <= req_funct3_i;
                  req_q.wdata  <= req_wdata_i;
                  addr_q       <= req_addr_i;
                  err_q        <= req_err;
                  rdata_q      <= '0;
               end
            end
            RDWAIT: rdata_q <= load_data;
            RESP: begin
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: ;
         endcase
      end
   end

   // Store lane replication: narrow data is copied into every lane so byte enables pick the target
   always_comb begin
      case (req_q.funct3[1:0])
         2'b00:   wdata_fmt = {4{req_q.wdata[7:0]}};
         2'b01:   wdata_fmt = {2{req_q.wdata[15:0]}};
         default: wdata_fmt = req_q.wdata;
      endcase
   end

   // Outputs decoded from state and latched request only; memory bus is zero outside ISSUE
   always_comb begin
      req_ready_o   = 1'b0;
      resp_valid_o  = 1'b0;
      resp_err_o    = 1'b0;
      mem_read_o    = 1'b0;
      mem_write_o   = 1'b0;
      mem_addr_o    = '0;
      mem_wdata_o   = '0;
      mem_byte_en_o = '0;
      case (state_q)
         IDLE:  req_ready_o = 1'b1;
         ISSUE: begin
            mem_read_o    = !req_q.we;
            mem_write_o   = req_q.we;
            mem_addr_o    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_o   = wdata_fmt;
            mem_byte_en_o = lsu_byte_en(req_q.funct3, addr_q[1:0]);
         end
         RESP: begin
            resp_valid_o = 1'b1;
            resp_err_o   = err_q;
         end
         default: ;
      endcase
   end

   assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed steps plus random traffic against a byte-addressed reference model.
// Latency: checks response cycle against the expected count for each request.
// Backpressure: memory model inserts mem_ready_i low cycles while a strobe is pending.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic        resp_valid_o;
   logic [31:0] resp_rdata_o;
   logic        resp_err_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [3:0]  mem_byte_en_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   // Word-organised memory device (1 KiB) and byte-addressed reference image
   logic [31:0] mem_words [0:255] = '{default: 32'h0};
   logic [7:0]  ref_bytes [0:1023] = '{default: 8'h0};

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_funct3_i  (req_funct3_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .resp_valid_o  (resp_valid_o),
      .resp_rdata_o  (resp_rdata_o),
      .resp_err_o    (resp_err_o),
      .mem_read_o    (mem_read_o),
      .mem_write_o   (mem_write_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_byte_en_o (mem_byte_en_o),
      .mem_rdata_i   (mem_rdata_i),
      .mem_ready_i   (mem_ready_i)
   );

   function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [3:0] be);
      logic [31:0] w;
      w = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
      return w;
   endfunction

   // Memory device: registered read data the cycle after an accepted read, garbage otherwise
   always @(posedge clk) begin
      if (mem_read_o && mem_ready_i) mem_rdata_i <= mem_words[mem_addr_o[9:2]];
      else                           mem_rdata_i <= $urandom;
      if (mem_write_o && mem_ready_i)
         mem_words[mem_addr_o[9:2]] <= merge_word(mem_words[mem_addr_o[9:2]], mem_wdata_o, mem_byte_en_o);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour from the access rules, in bytes rather than lanes
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output bit err, output int size,
                                 output logic [3:0] be, output logic [31:0] mwd,
                                 output logic [31:0] erd);
      int          off;
      bit          legal;
      logic [31:0] v;
      off = int'(addr[1:0]);
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      legal = (size != 0) && !(we && f3[2]);
      err   = !legal;
      be    = 4'h0;
      mwd   = 32'h0;
      erd   = 32'h0;
      if (legal) begin
         if ((off % size) != 0) err = 1'b1;
         be = 4'(((1 << size) - 1) << off);
         for (int i = 0; i < 4; i++)
            mwd[8*i +: 8] = 8'(wd >> (8 * (i % size)));
         if (!err && !we) begin
            v = 32'h0;
            for (int k = 0; k < size; k++)
               v = v | (32'(ref_bytes[10'(addr + 32'(k))]) << (8 * k));
            if ((f3 == 3'd0 || f3 == 3'd1) && v[8*size-1])
               v = v | (32'hFFFF_FFFF << (8 * size));
            erd = v;
         end
      end
   endfunction

   // One request end to end: accept, watch every cycle until the response, compare with the model
   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall, output logic [31:0] got);
      bit          err;
      int          size, exp_lat, lat, accepts, stall_left;
      logic [3:0]  be;
      logic [31:0] mwd, erd;
      model(we, f3, addr, wd, err, size, be, mwd, erd);
      exp_lat = err ? 1 : ((we ? 2 : 3) + stall);
      @(negedge clk);
      check("req_ready_before", 32'(req_ready_o), 32'd1);
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wd;
      mem_ready_i  = 1'b1;
      @(negedge clk);
      lat        = 0;
      accepts    = 0;
      stall_left = stall;
      for (int cyc = 1; cyc <= 30; cyc++) begin
         // Request inputs must be ignored while busy
         req_valid_i  = 1'($urandom_range(0, 1));
         req_we_i     = 1'($urandom);
         req_funct3_i = 3'($urandom);
         req_addr_i   = $urandom;
         req_wdata_i  = $urandom;
         if (resp_valid_o) begin
            lat = cyc;
            break;
         end
         if (mem_read_o || mem_write_o) begin
            check("mem_strobe", {30'b0, mem_read_o, mem_write_o},
                  err ? 32'h0 : {30'b0, !we, we});
            check("mem_addr", mem_addr_o, addr & ~32'h3);
            check("mem_byte_en", {28'b0, mem_byte_en_o}, {28'b0, be});
            check("mem_wdata", mem_wdata_o, mwd);
            if (stall_left > 0) begin
               mem_ready_i = 1'b0;
               stall_left--;
            end else begin
               mem_ready_i = 1'b1;
               accepts++;
            end
         end else begin
            check("mem_quiet", mem_addr_o | mem_wdata_o | {28'b0, mem_byte_en_o}, 32'h0);
            mem_ready_i = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      req_valid_i = 1'b0;
      mem_ready_i = 1'b1;
      check("latency", 32'(lat), 32'(exp_lat));
      check("mem_accepts", 32'(accepts), err ? 32'd0 : 32'd1);
      check("resp_err", 32'(resp_err_o), 32'(err));
      check("resp_rdata", resp_rdata_o, erd);
      check("ready_valid_overlap", 32'(req_ready_o), 32'd0);
      got = resp_rdata_o;
      if (!err && we)
         for (int k = 0; k < size; k++)
            ref_bytes[10'(addr + 32'(k))] = 8'(wd >> (8 * k));
   endtask

   initial begin
      logic [31:0] got;
      rst_n        = 1'b0;
      req_valid_i  = 1'b0;
      req_we_i     = 1'b0;
      req_funct3_i = 3'b000;
      req_addr_i   = 32'h0;
      req_wdata_i  = 32'h0;
      mem_ready_i  = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready_o), 32'd1);
      check("rst_resp", {29'b0, resp_valid_o, resp_err_o, mem_read_o | mem_write_o}, 32'h0);
      check("rst_rdata", resp_rdata_o, 32'h0);
      check("rst_mem", mem_addr_o | mem_wdata_o | {28'b0, mem_byte_en_o}, 32'h0);
      rst_n = 1'b1;

      // SW then LW
      run_req(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 0, got);
      run_req(1'b0, 3'b010, 32'h100, 32'h0, 0, got);
      check("lw_deadbeef", got, 32'hDEADBEEF);

      // Byte lanes on 0x80FF7F01
      run_req(1'b1, 3'b010, 32'h200, 32'h80FF7F01, 0, got);
      run_req(1'b0, 3'b000, 32'h201, 32'h0, 0, got);
      check("lb_201", got, 32'h0000007F);
      run_req(1'b1, 3'b000, 32'h203, 32'h000000AA, 0, got);
      run_req(1'b0, 3'b000, 32'h203, 32'h0, 0, got);
      check("lb_203", got, 32'hFFFFFFAA);
      run_req(1'b0, 3'b100, 32'h203, 32'h0, 0, got);
      check("lbu_203", got, 32'h000000AA);

      // Halfword
      run_req(1'b1, 3'b001, 32'h302, 32'h00008001, 0, got);
      run_req(1'b0, 3'b001, 32'h302, 32'h0, 0, got);
      check("lh_302", got, 32'hFFFF8001);
      run_req(1'b0, 3'b101, 32'h302, 32'h0, 0, got);
      check("lhu_302", got, 32'h00008001);

      // Misaligned and illegal
      run_req(1'b0, 3'b010, 32'h101, 32'h0, 0, got);
      run_req(1'b1, 3'b001, 32'h103, 32'h12345678, 0, got);
      run_req(1'b0, 3'b011, 32'h100, 32'h0, 0, got);
      run_req(1'b1, 3'b100, 32'h100, 32'h55, 0, got);

      // Backpressure: three stall cycles on a word load
      run_req(1'b0, 3'b010, 32'h100, 32'h0, 3, got);
      check("lw_stalled", got, 32'hDEADBEEF);

      // Reset while waiting for read data
      @(negedge clk);
      req_valid_i  = 1'b1;
      req_we_i     = 1'b0;
      req_funct3_i = 3'b010;
      req_addr_i   = 32'h100;
      mem_ready_i  = 1'b1;
      @(negedge clk);
      req_valid_i = 1'b0;
      check("rstmid_issue_read", 32'(mem_read_o), 32'd1);
      @(negedge clk);
      check("rstmid_rdwait_quiet", {30'b0, mem_read_o, mem_write_o}, 32'h0);
      rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_ready", 32'(req_ready_o), 32'd1);
      check("rstmid_resp", {30'b0, resp_valid_o, resp_err_o}, 32'h0);
      check("rstmid_rdata", resp_rdata_o, 32'h0);
      check("rstmid_mem", mem_addr_o | mem_wdata_o | {26'b0, mem_byte_en_o, mem_read_o, mem_write_o}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rstmid_no_late_resp", 32'(resp_valid_o), 32'd0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr;
         int          stall;
         we    = 1'($urandom_range(0, 1));
         f3    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 7))
                                            : 3'b010;
         addr  = 32'($urandom_range(0, 1023));
         stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
         run_req(we, f3, addr, $urandom, stall, got);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side bridge between the CPU execute/MEM stage and the word-organised data memory. It accepts one load or store per handshake, encoded by RV32 funct3. It checks alignment, drives the memory strobes, word address, byte enables and lane-replicated write data, and waits on `mem_ready_i`. For loads it captures the memory's registered read data and returns it lane-extracted and sign- or zero-extended.

## Interface
- `ADDR_WIDTH`, 32, byte-address width on both sides.
- `DATA_WIDTH`, 32, data width; only 32 is supported, and elaboration fails otherwise.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  CPU request valid.
- `req_ready_o`  out  1  high only in IDLE.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_funct3_i`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU. BU/HU are load-only.
- `req_addr_i`  in  ADDR_WIDTH  byte address.
- `req_wdata_i`  in  32  store data, right-justified.
- `resp_valid_o`  out  1  one-cycle completion pulse.
- `resp_rdata_o`  out  32  extended load data. 0 for stores and errors.
- `resp_err_o`  out  1  misaligned or illegal access. Qualified by `resp_valid_o`.
- `mem_read_o`, `mem_write_o`  out  1  memory strobes.
- `mem_addr_o`  out  ADDR_WIDTH  word-aligned address, with [1:0] = 00.
- `mem_wdata_o`  out  32  lane-replicated store data.
- `mem_byte_en_o`  out  4  byte enables.
- `mem_rdata_i`  in  32  memory read data. Valid the cycle after an accepted read.
- `mem_ready_i`  in  1  memory accepts the strobe this cycle.

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- **IDLE.** On `req_valid_i` the request is latched: we, funct3, addr, wdata.
  - Illegal: funct3 ∈ {011, 110, 111}, or a store with BU/HU.
  - Misaligned: H/HU/SH with addr[0]=1, or W with addr[1:0]≠00.
  - Illegal or misaligned → RESP with the error flag set, and no memory strobe is ever driven.
  - Otherwise → ISSUE.
- **ISSUE.** Exactly one strobe is high: `mem_read_o` = !we, `mem_write_o` = we.
  - If `mem_ready_i` is low, stay in ISSUE with all memory outputs held stable.
  - If `mem_ready_i` is high: a store → RESP; a load → RDWAIT.
- **RDWAIT.** No strobe is driven. `mem_rdata_i` is sampled, extracted and registered into `resp_rdata_o`. → RESP.
- **RESP.** `resp_valid_o` = 1 for exactly one cycle. → IDLE. A new request can be accepted on the following cycle.
- **Byte enables**, with a = addr[1:0]:
  - B: 0001 << a.
  - H: 0011 << a.
  - W: 1111.
  - Loads drive the same pattern as stores.
- **Write data.**
  - SB: byte replicated ×4.
  - SH: halfword replicated ×2.
  - SW: data passed unchanged.
- **Load extraction.** Shift `mem_rdata_i` right by 8·a. Then:
  - B: sign-extend bit 7.
  - BU: zero-extend the low byte.
  - H: sign-extend bit 15.
  - HU: zero-extend the low halfword.
  - W: pass unchanged.
- **Idle outputs.** When not in ISSUE: strobes = 0, and `mem_addr_o`, `mem_wdata_o`, `mem_byte_en_o` = 0.
- **Request inputs** are ignored outside IDLE.

## Timing
- **Reset values:** state IDLE; `req_ready_o` = 1; `resp_valid_o`, `resp_err_o`, `resp_rdata_o`, all `mem_*_o` = 0.
- Memory outputs are decoded from the state and latched registers only. There is no combinational path from `req_*` or `mem_ready_i` to `mem_*_o`.
- **Latency** (accept edge = cycle 0, `mem_ready_i` = 1):
  - Store: ISSUE in cycle 1, RESP in cycle 2.
  - Load: ISSUE in cycle 1, RDWAIT in cycle 2, RESP in cycle 3.
  - Error: RESP in cycle 1.
  - Each cycle of `mem_ready_i` low in ISSUE adds one cycle.
- **Throughput:** one request per 3 (store) or 4 (load) cycles.
- **Reset mid-operation:** `rst_n` low at any edge forces IDLE with all outputs at their reset values after that edge. The pending request is dropped with no response. A store already accepted by memory (ISSUE with `mem_ready_i` = 1) is not undone.
- **Ready/valid overlap:** `resp_valid_o` and `req_ready_o` are never high in the same cycle.

## Structure
- **Shared package `riscv_pkg`:**
  - funct3 constants: `LS_B`, `LS_H`, `LS_W`, `LS_BU`, `LS_HU`.
  - State enum `lsu_state_t` with values IDLE, ISSUE, RDWAIT, RESP.
  - A byte-enable helper function.
- **Sub-module `lsu_load_align`:** combinational. Inputs: rdata, a, funct3. Output: extended 32-bit data. Reused by the future cache fill path.
- **Top level:** the FSM, request latch and store lane formatting stay in `load_store_unit`.

## Test plan
- **SW then LW, ready tied 1.** SW to 0x100 with 0xDEADBEEF → strobe in cycle 1 with byte_en 1111, `mem_addr_o` 0x100. LW from 0x100 → `resp_rdata_o` = 0xDEADBEEF in cycle 3 with `resp_err_o` = 0.
- **SB/LB/LBU lanes.** Word 0x80FF7F01 at 0x200.
  - SB 0xAA to 0x203 → byte_en 1000, wdata 0xAAAAAAAA.
  - Word afterwards: LB from 0x203 → 0xFFFFFFAA. LBU from 0x203 → 0x000000AA.
  - On the original word: LB from 0x201 → 0x0000007F.
- **Halfword.** SH 0x8001 to 0x302 → byte_en 1100, wdata 0x80018001. LH from 0x302 → 0xFFFF8001. LHU from 0x302 → 0x00008001.
- **Misaligned and illegal.**
  - LW from 0x101, and SH to 0x103 → `resp_valid_o` + `resp_err_o` in cycle 1, no strobe ever, `resp_rdata_o` 0.
  - funct3 011 → error response.
  - SB with funct3 100 → error response.
- **Backpressure.** `mem_ready_i` low for 3 cycles during a LW → strobe, address and byte_en held constant. `resp_valid_o` in cycle 6. Exactly one accepted read.
- **Reset mid-load.** `rst_n` low during RDWAIT → next cycle IDLE, `req_ready_o` = 1, no `resp_valid_o`, all `mem_*_o` = 0.
